fetch_sequencer: RTL and testbench

- Controls the fetch stage of the RV32I core. Owns the PC register and chooses the next PC: reset vector, sequential (+4) or redirect.
- Issues single-outstanding requests to instruction memory over a req/gnt/rvalid handshake.
- Buffers one fetched instruction toward decode with valid/ready.
- Redirects (branch/jump/trap) take priority and squash stale in-flight or buffered fetches.

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/fetch_pc_reg.sv | 43 ++++
 rtl/fetch_sequencer.sv | 174 +++++++++++++++++
 tb/tb_fetch_sequencer.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the RV32I fetch stage.
//   fetch_state_e    : fetch FSM state encoding
//   PC_INCR          : sequential PC step in bytes
//   NOP_INSN_DEFAULT : addi x0,x0,0, shown on inst when nothing is buffered
//   word_align()     : clears the two byte-offset bits of an address
// ---------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        FS_IDLE,
        FS_REQ,
        FS_WAIT,
        FS_DRAIN
    } fetch_state_e;

    localparam logic [31:0] PC_INCR          = 32'd4;
    localparam logic [31:0] NOP_INSN_DEFAULT = 32'h0000_0013;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// ---------------------------------------------------------------------------
// fetch_pc_reg
// Program counter register with its next-PC selection (redirect, +4, hold).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (PC <= RESET_VECTOR)
//   load       : take load_pc next cycle (has priority over advance)
//   load_pc    : redirect target, already word aligned by the caller
//   advance    : step the PC by PC_INCR (32-bit wrap, no flag)
//   pc         : current PC value
// ---------------------------------------------------------------------------
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] load_pc,
    input  logic        advance,
    output logic [31:0] pc
);

    logic [31:0] pc_d;

    always_comb begin
        pc_d = pc;
        if (load) begin
            pc_d = load_pc;
        end else if (advance) begin
            pc_d = pc + PC_INCR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_VECTOR;
        end else begin
            pc <= pc_d;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
// Fetch stage controller: owns the PC, issues one outstanding instruction
// memory request at a time and buffers one fetched instruction for decode.
// Redirects from execute take priority and squash stale fetches.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   redirect_valid/redirect_pc : branch/jump/trap target (bits [1:0] ignored)
//   imem_req/imem_addr         : fetch request and byte address
//   imem_gnt                   : request accepted this cycle
//   imem_rvalid/imem_rdata     : returned instruction word (no backpressure)
//   inst_valid/inst/inst_pc    : buffered instruction toward decode
//   dec_ready                  : decode consumes inst this cycle
//   fetch_pc                   : current PC register value
// Optional build macro FETCH_PERF_CNT_EN adds perf_fetched / perf_stall
// wrapping event counters.
// ---------------------------------------------------------------------------
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN     = NOP_INSN_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        dec_ready,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall,
`endif
    output logic [31:0] fetch_pc
);

    fetch_state_e state_q;
    fetch_state_e state_d;

    logic [31:0] pc_q;
    logic [31:0] req_pc_q;
    logic [31:0] inst_q;
    logic [31:0] inst_pc_q;
    logic        inst_valid_q;

    logic redirect_act;
    logic slot_free;
    logic pc_advance;
    logic capture;

    // A redirect arriving before the first request has been issued is ignored.
    assign redirect_act = redirect_valid && (state_q != FS_IDLE);

    // The buffer can take a new fetch if it is empty or being drained now.
    assign slot_free = !inst_valid_q || dec_ready;

    fetch_pc_reg #(
        .RESET_VECTOR(RESET_VECTOR)
    ) u_pc_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (redirect_act),
        .load_pc(word_align(redirect_pc)),
        .advance(pc_advance),
        .pc     (pc_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // In WAIT the PC still equals the granted address, so stepping the PC
    // register yields req_pc + 4.
    always_comb begin
        state_d    = state_q;
        imem_req   = 1'b0;
        pc_advance = 1'b0;
        capture    = 1'b0;
        case (state_q)
            FS_IDLE: begin
                state_d = FS_REQ;
            end
            FS_REQ: begin
                imem_req = slot_free;
                if (slot_free && imem_gnt) begin
                    // A fetch granted alongside a redirect is already stale.
                    state_d = redirect_act ? FS_DRAIN : FS_WAIT;
                end
            end
            FS_WAIT: begin
                if (imem_rvalid) begin
                    state_d = FS_REQ;
                    if (!redirect_act) begin
                        capture    = 1'b1;
                        pc_advance = 1'b1;
                    end
                end else if (redirect_act) begin
                    state_d = FS_DRAIN;
                end
            end
            FS_DRAIN: begin
                if (imem_rvalid) begin
                    state_d = FS_REQ;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_pc_q <= RESET_VECTOR;
        end else if (imem_req && imem_gnt) begin
            req_pc_q <= pc_q;
        end
    end

    // Redirect squashes the buffered entry even when decode accepts it now.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_valid_q <= 1'b0;
            inst_q       <= NOP_INSN;
            inst_pc_q    <= 32'h0000_0000;
        end else if (redirect_act) begin
            inst_valid_q <= 1'b0;
        end else if (capture) begin
            inst_valid_q <= 1'b1;
            inst_q       <= imem_rdata;
            inst_pc_q    <= req_pc_q;
        end else if (inst_valid_q && dec_ready) begin
            inst_valid_q <= 1'b0;
        end
    end

    assign imem_addr  = pc_q;
    assign fetch_pc   = pc_q;
    assign inst_valid = inst_valid_q;
    assign inst       = inst_valid_q ? inst_q : NOP_INSN;
    assign inst_pc    = inst_pc_q;

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= 32'd0;
            perf_stall   <= 32'd0;
        end else if (inst_valid_q) begin
            if (dec_ready) begin
                perf_fetched <= perf_fetched + 32'd1;
            end else begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

    // Read data while a request is being offered means the memory answered
    // something that was never granted. IDLE is exempt: a response to a
    // request abandoned by reset may still trickle in right after release.
    a_no_rvalid_in_req: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(imem_rvalid && (state_q == FS_REQ))
    );

endmodule

// File: tb/tb_fetch_sequencer.sv
`timescale 1ns/1ps
module tb_fetch_sequencer;

    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] NOP          = 32'h0000_0013;
    localparam logic [31:0] KEY          = 32'hA5A5_A5A5;
    localparam int          RAND_CYCLES  = 3000;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        dec_ready;
    logic [31:0] fetch_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    fetch_sequencer #(
        .RESET_VECTOR(RESET_VECTOR),
        .NOP_INSN    (NOP)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .inst_valid    (inst_valid),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .dec_ready     (dec_ready),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetched  (perf_fetched),
        .perf_stall    (perf_stall),
`endif
        .fetch_pc      (fetch_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        ready;
        logic        redir;
        logic [31:0] redir_pc;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_inst;
    } vec_t;

    vec_t vecs[$];

    int compared   = 0;
    int mismatched = 0;

    // Random-phase reference model state
    logic [31:0] exp_pc;
    logic [31:0] pend_addr;
    logic [31:0] prev_inst;
    logic [31:0] prev_inst_pc;
    logic [31:0] prev_addr;
    bit          pending;
    bit          outstanding;
    bit          rvalid_now;
    bit          prev_redir;
    bit          prev_stall;
    bit          prev_req_wait;
    int          cd;
    int          consumed;
    int          idle_run;
    int unsigned model_fetched;
    int unsigned model_stall;

    // Instruction memory contents: every word is its address XOR a key.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return addr ^ KEY;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %08h, expected %08h", name, actual, expected);
        end
    endtask

    task automatic addVec(input logic gnt, input logic rvalid, input logic [31:0] rdata,
                          input logic ready, input logic redir, input logic [31:0] redir_pc,
                          input logic exp_req, input logic [31:0] exp_addr,
                          input logic exp_valid, input logic [31:0] exp_ipc);
        vec_t v;
        v.gnt       = gnt;
        v.rvalid    = rvalid;
        v.rdata     = rdata;
        v.ready     = ready;
        v.redir     = redir;
        v.redir_pc  = redir_pc;
        v.exp_req   = exp_req;
        v.exp_addr  = exp_addr;
        v.exp_valid = exp_valid;
        v.exp_pc    = exp_ipc;
        v.exp_inst  = exp_valid ? mem_word(exp_ipc) : NOP;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        imem_gnt       = v.gnt;
        imem_rvalid    = v.rvalid;
        imem_rdata     = v.rdata;
        dec_ready      = v.ready;
        redirect_valid = v.redir;
        redirect_pc    = v.redir_pc;
    endtask

    task automatic checkPerf(input string tag, input logic [31:0] fetched,
                             input logic [31:0] stalled);
`ifdef FETCH_PERF_CNT_EN
        checkOutput({tag, ".perf_fetched"}, perf_fetched, fetched);
        checkOutput({tag, ".perf_stall"}, perf_stall, stalled);
`else
        if (fetched != stalled) begin
            // counters absent in this build
        end
`endif
    endtask

    initial begin
        // Cycle-by-cycle directed table, starting in the first REQ cycle.
        //     gnt  rv  rdata                    rdy redir target           req addr           v  inst_pc
        addVec(1, 0, 0,                        1, 0, 0,              1, 32'h0000_0000, 0, 0);
        addVec(0, 1, mem_word(32'h0),          1, 0, 0,              0, 32'h0000_0000, 0, 0);
        addVec(1, 0, 0,                        1, 0, 0,              1, 32'h0000_0004, 1, 32'h0);
        addVec(0, 1, mem_word(32'h4),          1, 0, 0,              0, 32'h0000_0004, 0, 0);
        addVec(1, 0, 0,                        1, 0, 0,              1, 32'h0000_0008, 1, 32'h4);
        addVec(0, 1, mem_word(32'h8),          1, 0, 0,              0, 32'h0000_0008, 0, 0);
        addVec(1, 0, 0,                        1, 0, 0,              1, 32'h0000_000C, 1, 32'h8);
        addVec(0, 1, mem_word(32'hC),          0, 0, 0,              0, 32'h0000_000C, 0, 0);
        for (int k = 0; k < 5; k++)
            addVec(0, 0, 0,                    0, 0, 0,              0, 32'h0000_0010, 1, 32'hC);
        addVec(1, 0, 0,                        1, 0, 0,              1, 32'h0000_0010, 1, 32'hC);
        addVec(0, 1, mem_word(32'h10),         1, 0, 0,              0, 32'h0000_0010, 0, 0);
        addVec(0, 0, 0,                        0, 0, 0,              0, 32'h0000_0014, 1, 32'h10);
        addVec(0, 0, 0,                        1, 0, 0,              1, 32'h0000_0014, 1, 32'h10);
        addVec(0, 0, 0,                        1, 0, 0,              1, 32'h0000_0014, 0, 0);
        addVec(0, 0, 0,                        1, 1, 32'h0000_0203,  1, 32'h0000_0014, 0, 0);
        addVec(1, 0, 0,                        1, 0, 0,              1, 32'h0000_0200, 0, 0);
        addVec(0, 0, 0,                        1, 1, 32'h0000_0103,  0, 32'h0000_0200, 0, 0);
        addVec(0, 1, mem_word(32'h200),        1, 0, 0,              0, 32'h0000_0100, 0, 0);
        addVec(1, 0, 0,                        1, 1, 32'h0000_0040,  1, 32'h0000_0100, 0, 0);
        addVec(0, 1, mem_word(32'h100),        1, 0, 0,              0, 32'h0000_0040, 0, 0);
        addVec(1, 0, 0,                        1, 0, 0,              1, 32'h0000_0040, 0, 0);
        addVec(0, 1, mem_word(32'h40),         1, 0, 0,              0, 32'h0000_0040, 0, 0);
        addVec(1, 0, 0,                        1, 1, 32'h0000_0080,  1, 32'h0000_0044, 1, 32'h40);
        addVec(0, 1, mem_word(32'h44),         1, 0, 0,              0, 32'h0000_0080, 0, 0);
        addVec(1, 0, 0,                        1, 0, 0,              1, 32'h0000_0080, 0, 0);
        addVec(0, 1, mem_word(32'h80),         1, 1, 32'hFFFF_FFFC,  0, 32'h0000_0080, 0, 0);
        addVec(1, 0, 0,                        1, 0, 0,              1, 32'hFFFF_FFFC, 0, 0);
        addVec(0, 1, mem_word(32'hFFFF_FFFC),  1, 0, 0,              0, 32'hFFFF_FFFC, 0, 0);
        addVec(0, 0, 0,                        1, 0, 0,              1, 32'h0000_0000, 1, 32'hFFFF_FFFC);
        addVec(0, 0, 0,                        1, 0, 0,              1, 32'h0000_0000, 0, 0);

        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        dec_ready      = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset.req", imem_req, 1'b0);
        checkOutput("reset.addr", imem_addr, RESET_VECTOR);
        checkOutput("reset.valid", inst_valid, 1'b0);
        checkOutput("reset.inst", inst, NOP);
        checkOutput("reset.inst_pc", inst_pc, 32'h0);
        checkOutput("reset.fetch_pc", fetch_pc, RESET_VECTOR);
        checkPerf("reset", 32'd0, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("idle.req", imem_req, 1'b0);
        @(posedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("vec%0d.req", i), imem_req, vecs[i].exp_req);
            checkOutput($sformatf("vec%0d.addr", i), imem_addr, vecs[i].exp_addr);
            checkOutput($sformatf("vec%0d.fetch_pc", i), fetch_pc, vecs[i].exp_addr);
            checkOutput($sformatf("vec%0d.valid", i), inst_valid, vecs[i].exp_valid);
            checkOutput($sformatf("vec%0d.inst", i), inst, vecs[i].exp_inst);
            if (vecs[i].exp_valid)
                checkOutput($sformatf("vec%0d.inst_pc", i), inst_pc, vecs[i].exp_pc);
        end
        checkPerf("table", 32'd7, 32'd6);

        // Reset in the middle of WAIT, with a late response after release.
        @(negedge clk);
        applyStimulus('{1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0});
        #1;
        checkOutput("rstwait.req", imem_req, 1'b1);
        @(negedge clk);
        imem_gnt = 1'b0;
        #1;
        checkOutput("rstwait.wait_req", imem_req, 1'b0);
        rst_n       = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(32'h0);
        #1;
        checkOutput("rstwait.req_in_reset", imem_req, 1'b0);
        checkOutput("rstwait.inst_pc", inst_pc, 32'h0);
        checkOutput("rstwait.inst", inst, NOP);
        checkPerf("rstwait", 32'd0, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("rstwait.idle_req", imem_req, 1'b0);
        @(negedge clk);
        imem_rvalid = 1'b0;
        #1;
        checkOutput("rstwait.first_req", imem_req, 1'b1);
        checkOutput("rstwait.first_addr", imem_addr, RESET_VECTOR);
        checkOutput("rstwait.late_ignored", inst_valid, 1'b0);
        checkPerf("rstwait_rel", 32'd0, 32'd0);

        // Randomized phase against an architectural stream model: consumed
        // instructions must follow RESET_VECTOR, +4 each, jump on redirect.
        exp_pc        = RESET_VECTOR;
        pending       = 1'b0;
        cd            = 0;
        pend_addr     = 32'h0;
        prev_redir    = 1'b0;
        prev_stall    = 1'b0;
        prev_req_wait = 1'b0;
        prev_inst     = 32'h0;
        prev_inst_pc  = 32'h0;
        prev_addr     = 32'h0;
        consumed      = 0;
        idle_run      = 0;
        model_fetched = 0;
        model_stall   = 0;

        for (int cyc = 0; cyc < RAND_CYCLES; cyc++) begin
            @(negedge clk);
            outstanding = pending;
            rvalid_now  = pending && (cd == 0);
            imem_rvalid = rvalid_now;
            imem_rdata  = rvalid_now ? mem_word(pend_addr) : $urandom;
            dec_ready   = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 3))
                0:       redirect_pc = $urandom;
                1:       redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                default: redirect_pc = 32'($urandom_range(0, 255));
            endcase
            #1;
            imem_gnt = imem_req && ($urandom_range(0, 2) != 0);
            #1;

            if (!inst_valid) checkOutput("rnd.nop_when_empty", inst, NOP);
            if (prev_redir) checkOutput("rnd.squash", inst_valid, 1'b0);
            if (outstanding) checkOutput("rnd.single_outstanding", imem_req, 1'b0);
            if (inst_valid && !dec_ready) checkOutput("rnd.req_when_full", imem_req, 1'b0);
            if (prev_stall) begin
                checkOutput("rnd.hold_valid", inst_valid, 1'b1);
                checkOutput("rnd.hold_inst", inst, prev_inst);
                checkOutput("rnd.hold_inst_pc", inst_pc, prev_inst_pc);
            end
            if (prev_req_wait && imem_req) checkOutput("rnd.addr_hold", imem_addr, prev_addr);
            checkOutput("rnd.fetch_pc", fetch_pc, imem_addr);
            checkPerf("rnd", model_fetched, model_stall);

            if (inst_valid && dec_ready) begin
                checkOutput("rnd.inst_pc", inst_pc, exp_pc);
                checkOutput("rnd.inst", inst, mem_word(exp_pc));
                exp_pc = exp_pc + 32'd4;
                consumed++;
                idle_run = 0;
                model_fetched++;
            end else begin
                idle_run++;
                if (inst_valid) model_stall++;
            end
            if (redirect_valid) exp_pc = redirect_pc & ~32'd3;

            if (rvalid_now) pending = 1'b0;
            else if (pending) cd--;
            if (imem_req && imem_gnt) begin
                pending   = 1'b1;
                cd        = $urandom_range(0, 2);
                pend_addr = imem_addr;
            end

            prev_redir    = redirect_valid;
            prev_stall    = inst_valid && !dec_ready && !redirect_valid;
            prev_inst     = inst;
            prev_inst_pc  = inst_pc;
            prev_req_wait = imem_req && !imem_gnt && !redirect_valid;
            prev_addr     = imem_addr;

            if (idle_run > 200) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL rnd.liveness: got no delivery for %0d cycles, expected at most 200", idle_run);
                break;
            end
        end
        checkOutput("rnd.progress", 32'(consumed >= 150), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
